i2c_master_arbiter: RTL and testbench

- Shares the single I2C master core between up to NumReq reconfigurable application FSMs (ADT7410-style sensor controllers) inside the reconfigurable logic.
- Grants the core to one requester at a time, round-robin, and holds the grant for a full transaction plus FIFO read-out.
- Muxes the granted requester's control and data signals onto the core; routes Busy, Error and read data back.
- Sits between the application instances and the core ports of the reconfigurable-logic wrapper.

---
 rtl/i2c_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 48 ++++
 rtl/i2c_master_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_arb_pkg
//  Purpose  : Shared types and constants for the I2C master arbiter.
//             Provides the arbiter FSM state encoding and the data, read-count
//             and watchdog counter widths used by the I2C master core ports.
//  Revision : 1.0  initial release
// ============================================================================
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int I2C_DATA_W  = 8;
    localparam int I2C_RDCNT_W = 4;
    localparam int TIMEOUT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin priority select. Searches the request
//             vector starting one position after the last winner, wrapping
//             around, and returns the first set request.
//  Ports    : req_i       - request vector
//             last_i      - index of the previous winner
//             grant_oh_o  - one-hot winner (all zero when nothing requested)
//             grant_idx_o - winner index
//             valid_o     - at least one request is set
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [N-1:0]    grant_oh_o,
    output logic [IdxW-1:0] grant_idx_o,
    output logic            valid_o
);

    always_comb begin
        logic found;
        int   k;
        found       = 1'b0;
        grant_idx_o = '0;
        k           = 0;
        // Offsets 1..N visit every requester once, ending on last_i itself,
        // so the previous winner has the lowest priority.
        for (int i = 1; i <= N; i++) begin
            k = (int'(last_i) + i) % N;
            if (!found && req_i[k]) begin
                found       = 1'b1;
                grant_idx_o = IdxW'(k);
            end
        end
        valid_o                 = found;
        grant_oh_o              = '0;
        grant_oh_o[grant_idx_o] = found;
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_master_arbiter
//  Purpose  : Shares one I2C master core between NumReq application FSMs.
//             Round-robin grant, held for a full transaction plus FIFO
//             read-out; the granted requester's controls are muxed onto the
//             core, Busy/Error are routed back, read data is broadcast.
//  Ports    : Clk_i/Reset_i (async, active-high); Req_i request levels;
//             Grant_o one-hot registered grant; Done_o end-of-transaction
//             pulse; Timeout_o watchdog pulse; Req*_i / Req*_o requester side;
//             I2C_*_o / I2C_*_i core side.
//  Options  : I2C_ARB_TIMEOUT_EN - enables the watchdog that reclaims the core
//             from an owner idling in GRANTED or HOLD for TimeoutCycles clocks.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 1000
) (
    input  logic                          Clk_i,
    input  logic                          Reset_i,
    input  logic [NumReq-1:0]             Req_i,
    output logic [NumReq-1:0]             Grant_o,
    output logic [NumReq-1:0]             Done_o,
    output logic [NumReq-1:0]             Timeout_o,
    input  logic [NumReq-1:0]             ReqStartProcess_i,
    input  logic [NumReq-1:0]             ReqReceiveSend_n_i,
    input  logic [I2C_RDCNT_W*NumReq-1:0] ReqReadCount_i,
    input  logic [NumReq-1:0]             ReqFIFOWrite_i,
    input  logic [NumReq-1:0]             ReqFIFOReadNext_i,
    input  logic [I2C_DATA_W*NumReq-1:0]  ReqData_i,
    output logic [NumReq-1:0]             ReqBusy_o,
    output logic [NumReq-1:0]             ReqError_o,
    output logic [I2C_DATA_W-1:0]         ReqData_o,
    output logic                          I2C_StartProcess_o,
    output logic                          I2C_ReceiveSend_n_o,
    output logic                          I2C_FIFOWrite_o,
    output logic                          I2C_FIFOReadNext_o,
    output logic [I2C_RDCNT_W-1:0]        I2C_ReadCount_o,
    output logic [I2C_DATA_W-1:0]         I2C_Data_o,
    input  logic                          I2C_Busy_i,
    input  logic                          I2C_Error_i,
    input  logic [I2C_DATA_W-1:0]         I2C_Data_i
);

    localparam int IdxW = $clog2(NumReq);

    // Out-of-range configurations fail elaboration on an undefined module.
    generate
        if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_cfg
            i2c_master_arbiter_illegal_parameter u_bad ();
        end
    endgenerate

    state_t              state_q, state_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]     gidx_q, gidx_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [NumReq-1:0]   done_q, done_d;
    logic [NumReq-1:0]   pick_oh;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_valid;
    logic                req_g;

    rr_pick #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i       (Req_i),
        .last_i      (last_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .valid_o     (pick_valid)
    );

    assign req_g = Req_i[gidx_q];

`ifdef I2C_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [NumReq-1:0]    timeout_q, timeout_d;
`endif

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IdxW'(NumReq - 1);
            done_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            done_q    <= done_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        done_d  = '0;
        case (state_q)
            // Core Busy is not looked at here: a spurious Busy never blocks
            // arbitration.
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANTED;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    last_d  = pick_idx;
                end
            end
            GRANTED: begin
                if (I2C_Busy_i) begin
                    state_d = BUSY;
                end else if (!req_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            // A running transaction is never aborted, even if the owner
            // withdraws its request.
            BUSY: begin
                if (!I2C_Busy_i) begin
                    state_d = HOLD;
                    done_d  = grant_q;
                end
            end
            HOLD: begin
                if (req_g && I2C_Busy_i) begin
                    state_d = BUSY;
                end else if (!req_g) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

`ifdef I2C_ARB_TIMEOUT_EN
        // The counter only runs while the owner stays put in GRANTED/HOLD;
        // any state change (including entry to BUSY) restarts it.
        cnt_d     = '0;
        timeout_d = '0;
        if ((state_q == GRANTED || state_q == HOLD) && state_d == state_q) begin
            if (cnt_q == TIMEOUT_W'(TimeoutCycles - 1)) begin
                state_d   = IDLE;
                grant_d   = '0;
                timeout_d = grant_q;
                last_d    = gidx_q;
            end else begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
        end
`endif
    end

    // Grant is one-hot, so an AND-OR mux is sufficient; no grant gives zeros.
    always_comb begin
        I2C_StartProcess_o  = 1'b0;
        I2C_ReceiveSend_n_o = 1'b0;
        I2C_FIFOWrite_o     = 1'b0;
        I2C_FIFOReadNext_o  = 1'b0;
        I2C_ReadCount_o     = '0;
        I2C_Data_o          = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (grant_q[k]) begin
                I2C_StartProcess_o  = ReqStartProcess_i[k];
                I2C_ReceiveSend_n_o = ReqReceiveSend_n_i[k];
                I2C_FIFOWrite_o     = ReqFIFOWrite_i[k];
                I2C_FIFOReadNext_o  = ReqFIFOReadNext_i[k];
                I2C_ReadCount_o     = ReqReadCount_i[I2C_RDCNT_W*k +: I2C_RDCNT_W];
                I2C_Data_o          = ReqData_i[I2C_DATA_W*k +: I2C_DATA_W];
            end
        end
    end

    // Non-owners see the core as permanently busy and error-free.
    assign ReqBusy_o  = ~grant_q | {NumReq{I2C_Busy_i}};
    assign ReqError_o = grant_q & {NumReq{I2C_Error_i}};
    assign ReqData_o  = I2C_Data_i;
    assign Grant_o    = grant_q;
    assign Done_o     = done_q;

`ifdef I2C_ARB_TIMEOUT_EN
    assign Timeout_o = timeout_q;
`else
    assign Timeout_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master_arbiter
//  Purpose  : Self-checking bench for i2c_master_arbiter (NumReq=2,
//             TimeoutCycles=8). Directed scenarios plus a randomized loop
//             compared against a round-robin reference model.
//  Options  : I2C_ARB_TIMEOUT_EN selects the watchdog scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_master_arbiter;

    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req, start, rsn, fwr, frd;
    logic [4*NR-1:0] rdcnt;
    logic [8*NR-1:0] rdata;
    logic          busy, err;
    logic [7:0]    cdata;

    logic [NR-1:0] Grant_o, Done_o, Timeout_o, ReqBusy_o, ReqError_o;
    logic [7:0]    ReqData_o, I2C_Data_o;
    logic          I2C_StartProcess_o, I2C_ReceiveSend_n_o, I2C_FIFOWrite_o, I2C_FIFOReadNext_o;
    logic [3:0]    I2C_ReadCount_o;
    logic [15:0]   core_bus;

    int errors = 0;
    int checks = 0;
    int exp_last;

    always #5 clk = ~clk;

    assign core_bus = {I2C_StartProcess_o, I2C_ReceiveSend_n_o, I2C_FIFOWrite_o,
                       I2C_FIFOReadNext_o, I2C_ReadCount_o, I2C_Data_o};

    i2c_master_arbiter #(.NumReq(NR), .TimeoutCycles(8)) dut (
        .Clk_i(clk), .Reset_i(rst), .Req_i(req), .Grant_o(Grant_o), .Done_o(Done_o),
        .Timeout_o(Timeout_o), .ReqStartProcess_i(start), .ReqReceiveSend_n_i(rsn),
        .ReqReadCount_i(rdcnt), .ReqFIFOWrite_i(fwr), .ReqFIFOReadNext_i(frd),
        .ReqData_i(rdata), .ReqBusy_o(ReqBusy_o), .ReqError_o(ReqError_o),
        .ReqData_o(ReqData_o), .I2C_StartProcess_o(I2C_StartProcess_o),
        .I2C_ReceiveSend_n_o(I2C_ReceiveSend_n_o), .I2C_FIFOWrite_o(I2C_FIFOWrite_o),
        .I2C_FIFOReadNext_o(I2C_FIFOReadNext_o), .I2C_ReadCount_o(I2C_ReadCount_o),
        .I2C_Data_o(I2C_Data_o), .I2C_Busy_i(busy), .I2C_Error_i(err), .I2C_Data_i(cdata)
    );

    // Reference round-robin rule: first request after the previous winner.
    function automatic int model_pick(input logic [NR-1:0] r, input int last);
        for (int i = 1; i <= NR; i++) begin
            if (r[(last + i) % NR]) return (last + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; start = '0; rsn = '0; fwr = '0; frd = '0;
        rdcnt = '0; rdata = '0; busy = 1'b0; err = 1'b0; cdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        exp_last = NR - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1; start = '1; rsn = '1; fwr = '1; frd = '1;
        rdcnt = '1; rdata = '1; busy = 1'b0; err = 1'b1; cdata = 8'h3C;
        tick();
        checks++; if (Grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", Grant_o); end
        checks++; if (Done_o !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", Done_o); end
        checks++; if (Timeout_o !== 2'b00) begin errors++; $display("FAIL reset_timeout: got %b want 00", Timeout_o); end
        checks++; if (core_bus !== 16'h0000) begin errors++; $display("FAIL reset_core: got %h want 0000", core_bus); end
        checks++; if (ReqBusy_o !== 2'b11) begin errors++; $display("FAIL reset_reqbusy: got %b want 11", ReqBusy_o); end
        checks++; if (ReqError_o !== 2'b00) begin errors++; $display("FAIL reset_reqerror: got %b want 00", ReqError_o); end
        checks++; if (ReqData_o !== 8'h3C) begin errors++; $display("FAIL reset_reqdata: got %h want 3c", ReqData_o); end
        clear_inputs();
        tick();
        rst = 1'b0;
        exp_last = NR - 1;
    endtask

    task automatic test_first_grant();
        req = 2'b01; start = 2'b01;
        #1;
        checks++; if (Grant_o !== 2'b00) begin errors++; $display("FAIL first_latency: got %b want 00", Grant_o); end
        tick();
        exp_last = model_pick(req, exp_last);
        checks++; if (Grant_o !== onehot(exp_last)) begin errors++; $display("FAIL first_grant: got %b want %b", Grant_o, onehot(exp_last)); end
        checks++; if (I2C_StartProcess_o !== 1'b1) begin errors++; $display("FAIL first_start: got %b want 1", I2C_StartProcess_o); end
        checks++; if (ReqBusy_o !== 2'b10) begin errors++; $display("FAIL first_reqbusy: got %b want 10", ReqBusy_o); end
        start = 2'b10;
        #1;
        checks++; if (I2C_StartProcess_o !== 1'b0) begin errors++; $display("FAIL first_start_other: got %b want 0", I2C_StartProcess_o); end
    endtask

    task automatic test_transaction();
        int pulses;
        start = 2'b01; busy = 1'b1;
        tick();
        start = 2'b00;
        pulses = 0;
        repeat (19) begin
            tick();
            if (Done_o !== 2'b00) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL txn_done_early: got %0d pulses want 0", pulses); end
        busy = 1'b0;
        tick();
        checks++; if (Done_o !== 2'b01) begin errors++; $display("FAIL txn_done: got %b want 01", Done_o); end
        tick();
        checks++; if (Done_o !== 2'b00) begin errors++; $display("FAIL txn_done_width: got %b want 00", Done_o); end
        cdata = 8'hA5;
        for (int n = 0; n < 2; n++) begin
            frd = 2'b01;
            #1;
            checks++; if ({I2C_FIFOReadNext_o, ReqData_o} !== 9'h1A5) begin errors++; $display("FAIL txn_fifo_read: got %b/%h want 1/a5", I2C_FIFOReadNext_o, ReqData_o); end
            tick();
            frd = 2'b00;
            tick();
        end
        checks++; if (Grant_o !== 2'b01) begin errors++; $display("FAIL txn_hold: got %b want 01", Grant_o); end
        req = 2'b00;
        tick();
        checks++; if (Grant_o !== 2'b00) begin errors++; $display("FAIL txn_release: got %b want 00", Grant_o); end
    endtask

    task automatic test_rr_order();
        int want;
        do_reset();
        req = 2'b11; rdcnt = {4'd3, 4'd2};
        for (int t = 0; t < 4; t++) begin
            tick();
            want = t % 2;
            exp_last = model_pick(req, exp_last);
            checks++; if (Grant_o !== onehot(want)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", t, Grant_o, onehot(want)); end
            checks++; if (I2C_ReadCount_o !== ((want == 0) ? 4'd2 : 4'd3)) begin errors++; $display("FAIL rr_rdcnt%0d: got %0d want %0d", t, I2C_ReadCount_o, (want == 0) ? 2 : 3); end
            busy = 1'b1;
            tick();
            busy = 1'b0;
            tick();
            checks++; if (Done_o !== onehot(want)) begin errors++; $display("FAIL rr_done%0d: got %b want %b", t, Done_o, onehot(want)); end
            req[want] = 1'b0;
            tick();
            checks++; if (Grant_o !== 2'b00) begin errors++; $display("FAIL rr_release%0d: got %b want 00", t, Grant_o); end
            req = 2'b11;
        end
        req = 2'b00;
        tick();
        req = 2'b01; busy = 1'b1;
        tick();
        busy = 1'b0; req = 2'b00;
        tick();
        exp_last = 0;
    endtask

    task automatic test_drop_during_busy();
        req = 2'b01;
        tick();
        exp_last = model_pick(req, exp_last);
        checks++; if (Grant_o !== 2'b01) begin errors++; $display("FAIL drop_grant: got %b want 01", Grant_o); end
        busy = 1'b1;
        tick();
        req = 2'b00;
        repeat (5) tick();
        checks++; if (Grant_o !== 2'b01) begin errors++; $display("FAIL drop_held: got %b want 01", Grant_o); end
        busy = 1'b0;
        tick();
        checks++; if (Done_o !== 2'b01) begin errors++; $display("FAIL drop_done: got %b want 01", Done_o); end
        tick();
        checks++; if ({Grant_o, Done_o} !== 4'b0000) begin errors++; $display("FAIL drop_idle: got %b want 0000", {Grant_o, Done_o}); end
    endtask

    task automatic test_hold_timeout();
        int bad;
        req = 2'b10;
        tick();
        exp_last = model_pick(req, exp_last);
        checks++; if (Grant_o !== 2'b10) begin errors++; $display("FAIL hold_grant: got %b want 10", Grant_o); end
        bad = 0;
`ifdef I2C_ARB_TIMEOUT_EN
        repeat (7) begin
            tick();
            if (Grant_o !== 2'b10 || Timeout_o !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles want 0", bad); end
        tick();
        checks++; if ({Timeout_o, Grant_o} !== 4'b1000) begin errors++; $display("FAIL timeout_fire: got %b want 1000", {Timeout_o, Grant_o}); end
        req = 2'b00;
        tick();
        checks++; if (Timeout_o !== 2'b00) begin errors++; $display("FAIL timeout_width: got %b want 00", Timeout_o); end
`else
        repeat (120) begin
            tick();
            if (Grant_o !== 2'b10 || Timeout_o !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_persist: got %0d bad cycles want 0", bad); end
        req = 2'b00;
        tick();
        checks++; if (Grant_o !== 2'b00) begin errors++; $display("FAIL hold_release: got %b want 00", Grant_o); end
`endif
    endtask

    task automatic test_async_reset();
        req = 2'b01;
        tick();
        busy = 1'b1; start = 2'b01; rdata = 16'h00FF;
        tick();
        checks++; if (I2C_StartProcess_o !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", I2C_StartProcess_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (Grant_o !== 2'b00) begin errors++; $display("FAIL areset_grant: got %b want 00", Grant_o); end
        checks++; if (core_bus !== 16'h0000) begin errors++; $display("FAIL areset_core: got %h want 0000", core_bus); end
        tick();
        clear_inputs();
        rst = 1'b0;
        exp_last = NR - 1;
        req = 2'b11;
        tick();
        exp_last = model_pick(req, exp_last);
        checks++; if (Grant_o !== onehot(exp_last)) begin errors++; $display("FAIL areset_first: got %b want %b", Grant_o, onehot(exp_last)); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_random();
        int            owner, pulses, n;
        logic [NR-1:0] eg;
        logic [15:0]   exp_core;
        for (int it = 0; it < 100; it++) begin
            req  = NR'($urandom_range(1, 3));
            busy = 1'($urandom_range(0, 1));
            tick();
            owner    = model_pick(req, exp_last);
            exp_last = owner;
            eg       = onehot(owner);
            checks++; if (Grant_o !== eg) begin errors++; $display("FAIL rnd_grant it%0d: got %b want %b", it, Grant_o, eg); end
            busy = 1'b0;
            repeat (4) begin
                start = NR'($urandom); rsn = NR'($urandom); fwr = NR'($urandom); frd = NR'($urandom);
                rdcnt = 8'($urandom); rdata = 16'($urandom); err = 1'($urandom); cdata = 8'($urandom);
                req   = NR'($urandom) | eg;
                #1;
                exp_core = {start[owner], rsn[owner], fwr[owner], frd[owner],
                            rdcnt[4*owner +: 4], rdata[8*owner +: 8]};
                checks++; if (core_bus !== exp_core) begin errors++; $display("FAIL rnd_core it%0d: got %h want %h", it, core_bus, exp_core); end
                checks++; if ({ReqBusy_o, ReqError_o} !== {~eg, eg & {NR{err}}}) begin errors++; $display("FAIL rnd_back it%0d: got %b want %b", it, {ReqBusy_o, ReqError_o}, {~eg, eg & {NR{err}}}); end
                checks++; if (ReqData_o !== cdata) begin errors++; $display("FAIL rnd_rdata it%0d: got %h want %h", it, ReqData_o, cdata); end
                tick();
            end
            busy = 1'b1;
            tick();
            n = $urandom_range(1, 10);
            pulses = 0;
            repeat (n) begin
                req = NR'($urandom);
                tick();
                if (Done_o !== 2'b00 || Grant_o !== eg) pulses++;
            end
            checks++; if (pulses !== 0) begin errors++; $display("FAIL rnd_busy it%0d: got %0d bad cycles want 0", it, pulses); end
            busy = 1'b0;
            tick();
            checks++; if (Done_o !== eg) begin errors++; $display("FAIL rnd_done it%0d: got %b want %b", it, Done_o, eg); end
            req = 2'b00;
            tick();
            checks++; if (Grant_o !== 2'b00) begin errors++; $display("FAIL rnd_release it%0d: got %b want 00", it, Grant_o); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        exp_last = NR - 1;
        #3;
        test_reset();
        test_first_grant();
        test_transaction();
        test_rr_order();
        test_drop_during_busy();
        test_hold_timeout();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
